// File: rtl/mux_arb_pkg.sv
// rtl/mux_arb_pkg.sv - shared types and constants for the round-robin mux arbiter
package mux_arb_pkg;

    localparam int N_REQ = 4;
    localparam int SEL_W = $clog2(N_REQ);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN  = 2'd1,
        GAP  = 2'd2
    } state_t;

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - rotating-priority encoder; scans last_ptr+1, +2, ... and wraps
module rr_pick
    import mux_arb_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [SEL_W-1:0] last_ptr,
    output logic             any,
    output logic [SEL_W-1:0] win_idx
);

    logic [SEL_W-1:0] idx;

    // The offset of N_REQ wraps back to last_ptr, so the previous owner is checked last.
    always_comb begin
        any     = 1'b0;
        win_idx = '0;
        idx     = '0;
        for (int i = 1; i <= N_REQ; i++) begin
            idx = last_ptr + SEL_W'(i);
            if (!any && req[idx]) begin
                any     = 1'b1;
                win_idx = idx;
            end
        end
    end

endmodule

// File: rtl/mux_rr_arbiter.sv
// rtl/mux_rr_arbiter.sv - round-robin owner arbiter driving the select of a 4:1 mux
module mux_rr_arbiter
    import mux_arb_pkg::*;
#(
    parameter  int MAX_BEATS = 8,
    localparam int CNT_W     = $clog2(MAX_BEATS + 1)
)
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    input  logic [N_REQ-1:0] done,
    output logic [N_REQ-1:0] grant,
    output logic [SEL_W-1:0] sel,
    output logic             sel_valid,
    output logic [CNT_W-1:0] beat_cnt,
    output logic             timeout
);

    state_t           state_q;
    logic [N_REQ-1:0] grant_q;
    logic [SEL_W-1:0] sel_q;
    logic             sel_valid_q;
    logic [CNT_W-1:0] beat_cnt_q;
    logic             timeout_q;
    logic [SEL_W-1:0] last_ptr_q;

    logic             pick_any;
    logic [SEL_W-1:0] pick_idx;
    logic             owner_done;
    logic             owner_req;
    logic             last_beat;

    rr_pick u_rr_pick (
        .req      (req),
        .last_ptr (last_ptr_q),
        .any      (pick_any),
        .win_idx  (pick_idx)
    );

    // sel_q still names the owner during OWN, so it doubles as the owner index.
    assign owner_done = done[sel_q];
    assign owner_req  = req[sel_q];
    assign last_beat  = (beat_cnt_q == CNT_W'(MAX_BEATS - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            grant_q     <= '0;
            sel_q       <= '0;
            sel_valid_q <= 1'b0;
            beat_cnt_q  <= '0;
            timeout_q   <= 1'b0;
            last_ptr_q  <= SEL_W'(N_REQ - 1);
        end else begin
            timeout_q <= 1'b0;
            case (state_q)
                IDLE, GAP: begin
                    beat_cnt_q <= '0;
                    if (pick_any) begin
                        state_q     <= OWN;
                        grant_q     <= N_REQ'(1) << pick_idx;
                        sel_q       <= pick_idx;
                        sel_valid_q <= 1'b1;
                    end else begin
                        state_q     <= IDLE;
                        grant_q     <= '0;
                        sel_valid_q <= 1'b0;
                    end
                end
                OWN: begin
                    if (owner_done || !owner_req || last_beat) begin
                        state_q     <= GAP;
                        grant_q     <= '0;
                        sel_valid_q <= 1'b0;
                        beat_cnt_q  <= '0;
                        last_ptr_q  <= sel_q;
                        timeout_q   <= !owner_done && owner_req;
                    end else begin
                        beat_cnt_q <= beat_cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    grant_q     <= '0;
                    sel_valid_q <= 1'b0;
                    beat_cnt_q  <= '0;
                end
            endcase
        end
    end

    assign grant     = grant_q;
    assign sel       = sel_q;
    assign sel_valid = sel_valid_q;
    assign beat_cnt  = beat_cnt_q;
    assign timeout   = timeout_q;

endmodule
